// File: rtl/tl_pkg.sv
// Shared types and helpers for the traffic-light phase sequencer:
// state encoding, lamp patterns and a BCD decrement.
package tl_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED1  = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED2  = 3'd5,
        EMERG = 3'd6
    } tl_state_e;

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    // Two-digit BCD decrement; caller guarantees v != 8'h00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
        else                r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second tick divider: down-counter reloading TICK_DIV-1 at zero;
// tick is high for the enabled cycle in which the counter sits at zero.
module tl_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);
    import tl_pkg::*;

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] RELOAD = W'(TICK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (enable) begin
            if (div_q == '0) div_d = RELOAD;
            else             div_d = div_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= RELOAD;
        else     div_q <= div_d;
    end

    assign tick = enable && (div_q == '0);

endmodule

// File: rtl/tl_phase_sequencer.sv
// Two-direction intersection sequencer: normal six-phase ring timed by a BCD
// seconds countdown, latched pedestrian walk requests and emergency preemption.
module tl_phase_sequencer #(
    parameter int         TICK_DIV = 50_000_000,
    parameter logic [7:0] GREEN_NS = 8'h25,
    parameter logic [7:0] GREEN_EW = 8'h25,
    parameter logic [7:0] YELLOW   = 8'h04,
    parameter logic [7:0] ALL_RED  = 8'h02
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       emerg_req,
    input  logic       emerg_dir,
    output logic [2:0] lamp_ns,
    output logic [2:0] lamp_ew,
    output logic [7:0] count,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase
);
    import tl_pkg::*;

    tl_state_e  state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       edir_q, edir_d;
    logic       pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
    logic       prev_ns_q, prev_ns_d, prev_ew_q, prev_ew_d;
    logic       walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
    logic [2:0] lamp_ns_q, lamp_ns_d, lamp_ew_q, lamp_ew_d;
    logic       tick;

    tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (CLOCK_50),
        .rst    (reset),
        .enable (enable),
        .tick   (tick)
    );

    function automatic tl_state_e ring_next(input tl_state_e s);
        tl_state_e n;
        case (s)
            NS_G:    n = NS_Y;
            NS_Y:    n = RED1;
            RED1:    n = EW_G;
            EW_G:    n = EW_Y;
            EW_Y:    n = RED2;
            default: n = NS_G;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] duration(input tl_state_e s);
        logic [7:0] d;
        case (s)
            NS_G:       d = GREEN_NS;
            EW_G:       d = GREEN_EW;
            NS_Y, EW_Y: d = YELLOW;
            RED1, RED2: d = ALL_RED;
            default:    d = 8'h00;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        edir_d    = edir_q;
        pend_ns_d = pend_ns_q;
        pend_ew_d = pend_ew_q;
        prev_ns_d = prev_ns_q;
        prev_ew_d = prev_ew_q;
        walk_ns_d = walk_ns_q;
        walk_ew_d = walk_ew_q;
        lamp_ns_d = lamp_ns_q;
        lamp_ew_d = lamp_ew_q;
        if (enable) begin
            prev_ns_d = ped_req_ns;
            prev_ew_d = ped_req_ew;
            // Emergency in a green acts every clock and overrides count expiry.
            if (emerg_req && (state_q == NS_G || state_q == EW_G)) begin
                if ((state_q == EW_G) == emerg_dir) begin
                    state_d = EMERG;
                    count_d = 8'h00;
                    edir_d  = emerg_dir;
                end else begin
                    state_d = (state_q == NS_G) ? NS_Y : EW_Y;
                    count_d = YELLOW;
                end
            end else if (state_q == EMERG) begin
                count_d = 8'h00;
                if (!emerg_req) begin
                    state_d = edir_q ? EW_Y : NS_Y;
                    count_d = YELLOW;
                end
            end else if (tick) begin
                if (count_q != 8'h00) begin
                    count_d = bcd_dec(count_q);
                end else if (emerg_req && (state_q == RED1 || state_q == RED2)) begin
                    state_d = EMERG;
                    count_d = 8'h00;
                    edir_d  = emerg_dir;
                end else begin
                    state_d = ring_next(state_q);
                    count_d = duration(ring_next(state_q));
                end
            end

            // Walk is decided on green entry from the flag as it stood before this edge.
            walk_ns_d = (state_d == NS_G) && ((state_q == NS_G) ? walk_ns_q : pend_ns_q);
            walk_ew_d = (state_d == EW_G) && ((state_q == EW_G) ? walk_ew_q : pend_ew_q);
            pend_ns_d = (pend_ns_q && !(state_d == NS_G && state_q != NS_G))
                        || (ped_req_ns && !prev_ns_q);
            pend_ew_d = (pend_ew_q && !(state_d == EW_G && state_q != EW_G))
                        || (ped_req_ew && !prev_ew_q);

            case (state_d)
                NS_G:    begin lamp_ns_d = LAMP_G; lamp_ew_d = LAMP_R; end
                NS_Y:    begin lamp_ns_d = LAMP_Y; lamp_ew_d = LAMP_R; end
                EW_G:    begin lamp_ns_d = LAMP_R; lamp_ew_d = LAMP_G; end
                EW_Y:    begin lamp_ns_d = LAMP_R; lamp_ew_d = LAMP_Y; end
                EMERG:   begin
                    lamp_ns_d = edir_d ? LAMP_R : LAMP_G;
                    lamp_ew_d = edir_d ? LAMP_G : LAMP_R;
                end
                default: begin lamp_ns_d = LAMP_R; lamp_ew_d = LAMP_R; end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= NS_G;
            count_q   <= GREEN_NS;
            edir_q    <= 1'b0;
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            prev_ns_q <= 1'b0;
            prev_ew_q <= 1'b0;
            walk_ns_q <= 1'b1;
            walk_ew_q <= 1'b0;
            lamp_ns_q <= LAMP_G;
            lamp_ew_q <= LAMP_R;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            edir_q    <= edir_d;
            pend_ns_q <= pend_ns_d;
            pend_ew_q <= pend_ew_d;
            prev_ns_q <= prev_ns_d;
            prev_ew_q <= prev_ew_d;
            walk_ns_q <= walk_ns_d;
            walk_ew_q <= walk_ew_d;
            lamp_ns_q <= lamp_ns_d;
            lamp_ew_q <= lamp_ew_d;
        end
    end

    assign lamp_ns = lamp_ns_q;
    assign lamp_ew = lamp_ew_q;
    assign count   = count_q;
    assign walk_ns = walk_ns_q;
    assign walk_ew = walk_ew_q;
    assign phase   = state_q;

endmodule
